regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised general-purpose register file for the PicoMIPS datapath. It adds the following over the fixed 8-bit/32-entry file:
- a dedicated write-address port, separate from the read addresses
- configurable width, depth and zero-register mode
- optional same-cycle write-to-read bypass
- a per-register busy scoreboard so multi-cycle units can reserve a destination and the decoder can detect RAW hazards

It sits between the decoder (read/reserve) and the writeback stage (write).

Parameters:
N, 8, data width in bits
NREG, 32, number of registers (2..64, need not be a power of 2)
AW, $clog2(NREG), address width (derived; do not override)
BYPASS, 1, 1 = write data forwarded to same-cycle reads of the written address
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, never busy

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
we  input  1  write enable
waddr  input  AW  write address
wdata  input  N  write data
raddr1  input  AW  read port 1 address
raddr2  input  AW  read port 2 address
rdata1  output  N  read port 1 data (combinational)
rdata2  output  N  read port 2 data (combinational)
rbusy1  output  1  register at raddr1 has a pending reservation
rbusy2  output  1  register at raddr2 has a pending reservation
rsv  input  1  reserve request for rsv_addr
rsv_addr  input  AW  register to reserve
rsv_ok  output  1  reservation accepted this cycle (combinational)
busy_any  output  1  OR of all busy bits (registered state)

Behaviour:
- Reset:
  - Synchronous, active-high: on a rising clk with reset=1, all registers clear to 0 and all busy bits clear to 0.
  - reset overrides we and rsv in the same cycle.
  - Outputs while in reset follow the combinational rules below using the cleared state. After reset, rdata*=0, rbusy*=0 and busy_any=0.
- Invalid and zero addresses:
  - Address a is valid iff a < NREG.
  - Address a is zero-reg iff ZERO_REG=1 and a==0.
- Write:
  - On the clk edge with we=1, reset=0, waddr valid and not zero-reg: gpr[waddr] <= wdata and busy[waddr] <= 0.
  - Otherwise the write is ignored.
  - There is one write per cycle.
- Read (per port k), combinational, zero latency, priority order:
  1. Invalid or zero-reg address -> rdata=0, rbusy=0.
  2. BYPASS=1 and we=1 and waddr==raddr -> rdata=wdata, rbusy=0.
  3. Otherwise -> rdata=gpr[raddr], rbusy=busy[raddr].
  - With BYPASS=0, a read of the address being written returns the old value; the new value is visible the cycle after the edge.
- Reserve (scoreboard):
  - rsv_ok = rsv and reset=0 and rsv_addr valid and (busy[rsv_addr]==0, or we=1 with waddr==rsv_addr).
  - A zero-reg rsv_addr gives rsv_ok=1 but sets no bit. It is a no-op accept.
  - On the edge with rsv_ok=1 and a non-zero-reg address, busy[rsv_addr] <= 1.
  - Request to a busy register with no same-cycle write -> rsv_ok=0 and state is unchanged. The requester must hold rsv and retry.
  - Simultaneous write and reserve of the same address: data is written AND busy ends at 1. Set wins over clear.
  - Write to a non-busy register is legal and leaves busy=0.
- busy_any: registered OR of the busy vector, updated with it (reflects post-edge state).
- Width rule: wdata is stored unmodified. There is no sign/zero extension inside the block.
- Non-power-of-2 NREG: out-of-range writes are ignored, reads return 0, and rsv_ok=0.

Test Plan:
1. Reset, then write 0xA5 to r3 and 0x5A to r7; read r3/r7 next cycle -> 0xA5/0x5A; read r0 -> 0x00.
2. With ZERO_REG=1, write 0xFF to r0 -> r0 still reads 0x00. Reserve r0 -> rsv_ok=1, busy_any stays 0.
3. Bypass check: with BYPASS=1, we=1, waddr=5, wdata=0x3C, raddr1=5 -> rdata1=0x3C in the same cycle. With BYPASS=0, the same stimulus gives the old r5 value, then 0x3C one cycle later.
4. Scoreboard: reserve r4 -> rsv_ok=1, then rbusy1=1 for raddr1=4 and busy_any=1. A second reserve of r4 -> rsv_ok=0. Write 0x11 to r4 -> next cycle rbusy1=0, rdata1=0x11, busy_any=0.
5. Simultaneous write and reserve of r9: busy r9, we=1 waddr=9 wdata=0x77, rsv=1 rsv_addr=9 -> rsv_ok=1. Next cycle r9=0x77 and busy stays 1.
6. Reset mid-operation: with r2 busy and holding 0x42, assert reset for one cycle with we=1 to r2 -> afterwards r2=0, all busy=0, busy_any=0. Also run NREG=24: write to address 30 is ignored and reading 30 returns 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional same-cycle write bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int N        = 8,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [N-1:0]  rdata1,
  output logic [N-1:0]  rdata2,
  output logic          rbusy1,
  output logic          rbusy2,
  input  logic          rsv,
  input  logic [AW-1:0] rsv_addr,
  output logic          rsv_ok,
  output logic          busy_any
);

  logic [N-1:0]    gpr [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            wr_en;
  logic            set_en;

  logic [AW-1:0]   raddr_v [2];
  logic [N-1:0]    rdata_v [2];
  logic            rbusy_v [2];

  // NREG need not be a power of two, so the top of the address space may be unmapped.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  function automatic logic addr_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign wr_en  = we && !reset && addr_valid(waddr) && !addr_zero(waddr);

  assign rsv_ok = rsv && !reset && addr_valid(rsv_addr) &&
                  (!busy[rsv_addr] || (we && (waddr == rsv_addr)));

  // A zero-register reservation is accepted but never marks anything busy.
  assign set_en = rsv_ok && !addr_zero(rsv_addr);

  always_comb begin
    busy_nxt = busy;
    if (reset) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)
        busy_nxt[waddr] = 1'b0;
      // Applied after the clear so a same-cycle reserve of the written register wins.
      if (set_en)
        busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    busy     <= busy_nxt;
    busy_any <= |busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        gpr[i] <= '0;
    end else if (wr_en) begin
      gpr[waddr] <= wdata;
    end
  end

  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      rdata_v[k] = '0;
      rbusy_v[k] = 1'b0;
      if (addr_valid(raddr_v[k]) && !addr_zero(raddr_v[k])) begin
        if (BYPASS && we && (waddr == raddr_v[k])) begin
          rdata_v[k] = wdata;
        end else begin
          rdata_v[k] = gpr[raddr_v[k]];
          rbusy_v[k] = busy[raddr_v[k]];
        end
      end
    end
  end

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign rbusy1 = rbusy_v[0];
  assign rbusy2 = rbusy_v[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations driven in parallel, checked against
// an array-based reference model plus directed literal checks.
module tb_regfile_sb;

  logic       clk;
  logic       reset;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [4:0] raddr1;
  logic [4:0] raddr2;
  logic       rsv;
  logic [4:0] rsv_addr;

  logic [7:0] rd1 [3];
  logic [7:0] rd2 [3];
  logic       rb1 [3];
  logic       rb2 [3];
  logic       rok [3];
  logic       bany [3];

  // config 0: defaults; 1: no bypass, no zero reg; 2: 24 registers
  int nreg_c [3] = '{32, 32, 24};
  bit byp_c  [3] = '{1'b1, 1'b0, 1'b1};
  bit zr_c   [3] = '{1'b1, 1'b0, 1'b1};

  logic [7:0] mg [3][32];
  bit         mb [3][32];

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
    .rbusy1(rb1[0]), .rbusy2(rb2[0]), .rsv(rsv), .rsv_addr(rsv_addr),
    .rsv_ok(rok[0]), .busy_any(bany[0])
  );

  regfile_sb #(.N(8), .NREG(32), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
    .rbusy1(rb1[1]), .rbusy2(rb2[1]), .rsv(rsv), .rsv_addr(rsv_addr),
    .rsv_ok(rok[1]), .busy_any(bany[1])
  );

  regfile_sb #(.N(8), .NREG(24), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_24 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
    .rbusy1(rb1[2]), .rbusy2(rb2[2]), .rsv(rsv), .rsv_addr(rsv_addr),
    .rsv_ok(rok[2]), .busy_any(bany[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid(int c, logic [4:0] a);
    return int'(a) < nreg_c[c];
  endfunction

  function automatic bit m_zero(int c, logic [4:0] a);
    return zr_c[c] && (a == 5'd0);
  endfunction

  // {busy, data} as seen by a read of address a
  function automatic logic [8:0] m_read(int c, logic [4:0] a);
    if (!m_valid(c, a) || m_zero(c, a))
      return 9'd0;
    if (byp_c[c] && we && (waddr == a))
      return {1'b0, wdata};
    return {mb[c][a], mg[c][a]};
  endfunction

  function automatic bit m_rsv_ok(int c);
    return rsv && !reset && m_valid(c, rsv_addr) &&
           (!mb[c][rsv_addr] || (we && (waddr == rsv_addr)));
  endfunction

  function automatic bit m_busy_any(int c);
    bit any = 1'b0;
    for (int i = 0; i < 32; i++)
      any |= mb[c][i];
    return any;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [7:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic rv, input logic [4:0] ra);
    reset = r; we = w; waddr = wa; wdata = wd;
    raddr1 = a1; raddr2 = a2; rsv = rv; rsv_addr = ra;
    #2;
  endtask

  task automatic verify();
    logic [8:0] e1;
    logic [8:0] e2;
    for (int c = 0; c < 3; c++) begin
      e1 = m_read(c, raddr1);
      e2 = m_read(c, raddr2);
      check($sformatf("c%0d.rdata1", c), 32'(rd1[c]), 32'(e1[7:0]));
      check($sformatf("c%0d.rdata2", c), 32'(rd2[c]), 32'(e2[7:0]));
      check($sformatf("c%0d.rbusy1", c), 32'(rb1[c]), 32'(e1[8]));
      check($sformatf("c%0d.rbusy2", c), 32'(rb2[c]), 32'(e2[8]));
      check($sformatf("c%0d.rsv_ok", c), 32'(rok[c]), 32'(m_rsv_ok(c)));
      check($sformatf("c%0d.busy_any", c), 32'(bany[c]), 32'(m_busy_any(c)));
    end
  endtask

  task automatic tick();
    bit ok [3];
    for (int c = 0; c < 3; c++)
      ok[c] = m_rsv_ok(c);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          mg[c][i] = 8'h00;
          mb[c][i] = 1'b0;
        end
      end else begin
        if (we && m_valid(c, waddr) && !m_zero(c, waddr)) begin
          mg[c][waddr] = wdata;
          mb[c][waddr] = 1'b0;
        end
        if (ok[c] && !m_zero(c, rsv_addr))
          mb[c][rsv_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [7:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic rv, input logic [4:0] ra);
    drive(r, w, wa, wd, a1, a2, rv, ra);
    verify();
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();

    // reset state
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd3, 5'd7, 1'b0, 5'd0);
    verify();
    check("rst.rdata1", 32'(rd1[0]), 32'h0);
    check("rst.busy_any", 32'(bany[0]), 32'h0);
    tick();

    // basic writes and reads
    step(1'b0, 1'b1, 5'd3, 8'hA5, 5'd0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 8'h5A, 5'd0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd3, 5'd7, 1'b0, 5'd0);
    verify();
    check("wr.r3", 32'(rd1[0]), 32'hA5);
    check("wr.r7", 32'(rd2[0]), 32'h5A);
    tick();

    // zero register: write ignored, reserve is a no-op accept
    step(1'b0, 1'b1, 5'd0, 8'hFF, 5'd1, 5'd2, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b1, 5'd0);
    verify();
    check("zr.r0", 32'(rd1[0]), 32'h00);
    check("zr.rsv_ok", 32'(rok[0]), 32'h1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
    verify();
    check("zr.busy_any", 32'(bany[0]), 32'h0);
    tick();

    // bypass vs no bypass
    drive(1'b0, 1'b1, 5'd5, 8'h3C, 5'd5, 5'd3, 1'b0, 5'd0);
    verify();
    check("byp.same_cycle", 32'(rd1[0]), 32'h3C);
    check("nobyp.old", 32'(rd1[1]), 32'h00);
    tick();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd5, 5'd3, 1'b0, 5'd0);
    verify();
    check("nobyp.next", 32'(rd1[1]), 32'h3C);
    tick();

    // scoreboard reserve / refuse / release
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b1, 5'd4);
    verify();
    check("sb.rsv_ok1", 32'(rok[0]), 32'h1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b1, 5'd4);
    verify();
    check("sb.rbusy1", 32'(rb1[0]), 32'h1);
    check("sb.busy_any", 32'(bany[0]), 32'h1);
    check("sb.rsv_ok2", 32'(rok[0]), 32'h0);
    tick();
    step(1'b0, 1'b1, 5'd4, 8'h11, 5'd0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd4, 5'd0, 1'b0, 5'd0);
    verify();
    check("sb.rel_busy", 32'(rb1[0]), 32'h0);
    check("sb.rel_data", 32'(rd1[0]), 32'h11);
    check("sb.rel_any", 32'(bany[0]), 32'h0);
    tick();

    // simultaneous write and reserve: set wins
    step(1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b1, 5'd9);
    drive(1'b0, 1'b1, 5'd9, 8'h77, 5'd0, 5'd0, 1'b1, 5'd9);
    verify();
    check("wr_rsv.ok", 32'(rok[0]), 32'h1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd9, 5'd0, 1'b0, 5'd0);
    verify();
    check("wr_rsv.data", 32'(rd1[0]), 32'h77);
    check("wr_rsv.busy", 32'(rb1[0]), 32'h1);
    tick();

    // reset mid-operation overrides write
    step(1'b0, 1'b1, 5'd2, 8'h42, 5'd0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 1'b1, 5'd2);
    step(1'b1, 1'b1, 5'd2, 8'h99, 5'd2, 5'd9, 1'b1, 5'd3);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd2, 5'd9, 1'b0, 5'd0);
    verify();
    check("mid_rst.r2", 32'(rd1[0]), 32'h00);
    check("mid_rst.rbusy", 32'(rb1[0]), 32'h0);
    check("mid_rst.busy_any", 32'(bany[0]), 32'h0);
    tick();

    // out-of-range address on the 24-entry file
    drive(1'b0, 1'b1, 5'd30, 8'hEE, 5'd30, 5'd30, 1'b0, 5'd0);
    verify();
    check("oor.byp_read", 32'(rd1[2]), 32'h00);
    tick();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 5'd30, 5'd23, 1'b1, 5'd30);
    verify();
    check("oor.read", 32'(rd1[2]), 32'h00);
    check("oor.rsv_ok", 32'(rok[2]), 32'h0);
    check("oor.full_read", 32'(rd1[0]), 32'hEE);
    tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)),
           8'($urandom),
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
